// File: rtl/vlsu_seg_resp_collector_pkg.sv
// ============================================================================
// Module      : VlsuPkg
// Description : Shared VLSU types for the segment response collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package VlsuPkg;

  localparam int SLEN     = 256;
  localparam int NB       = SLEN / 4;
  localparam int NB_W     = $clog2(NB);
  localparam int TXN_BITS = 8;

  typedef struct packed {
    logic [NB_W-1:0]     page_off;
    logic [TXN_BITS-1:0] txn_num;
    logic [NB_W:0]       ltn;
    logic                req_last;
  } seg_meta_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } col_state_e;

  // Nibble i is enabled when lo <= i < hi.
  function automatic logic [NB-1:0] nbe_mask(input logic [NB_W-1:0] lo,
                                             input logic [NB_W:0]   hi);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i >= int'(lo)) && (i < int'(hi));
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vlsu_meta_fifo.sv
// ============================================================================
// Module      : vlsu_meta_fifo
// Description : Valid/ready FIFO of segment metadata, no push bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vlsu_meta_fifo
  import VlsuPkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push_valid,
  output logic                     o_push_ready,
  input  seg_meta_t                i_push_data,
  output logic                     o_pop_valid,
  input  logic                     i_pop_ready,
  output seg_meta_t                o_pop_data,
  output logic [$clog2(DEPTH):0]   o_count_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = DEPTH[PTR_W:0];

  seg_meta_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign w_full       = (r_count == C_FULL);
  assign w_empty      = (r_count == '0);
  assign w_push       = i_push_valid && !w_full;
  assign w_pop        = i_pop_ready && !w_empty;
  assign o_push_ready = !w_full;
  assign o_pop_valid  = !w_empty;
  assign o_pop_data   = r_mem[r_rd_ptr];

  always_comb begin
    o_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   o_count_nxt = r_count + (PTR_W+1)'(1);
      2'b01:   o_count_nxt = r_count - (PTR_W+1)'(1);
      default: o_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= o_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/vlsu_seg_resp_collector.sv
// ============================================================================
// Module      : vlsu_seg_resp_collector
// Description : Tags bus read beats with nibble enables and segment/request
//               boundaries, forwarding them through a registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vlsu_seg_resp_collector
  import VlsuPkg::*;
#(
  parameter int SLEN       = VlsuPkg::SLEN,
  parameter int TXN_BITS   = VlsuPkg::TXN_BITS,
  parameter int META_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           seg_valid,
  output logic                           seg_ready,
  input  logic [$clog2(SLEN/4)-1:0]      seg_page_off,
  input  logic [TXN_BITS-1:0]            seg_txn_num,
  input  logic [$clog2(SLEN/4):0]        seg_ltn,
  input  logic                           seg_req_last,
  input  logic                           rsp_valid,
  output logic                           rsp_ready,
  input  logic [SLEN-1:0]                rsp_data,
  input  logic                           rsp_err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SLEN-1:0]                out_data,
  output logic [SLEN/4-1:0]              out_nbe,
  output logic                           out_seg_last,
  output logic                           out_req_last,
  output logic                           out_err
);

  localparam logic [NB_W:0] C_NB_FULL = (NB_W+1)'(NB);

  col_state_e                    r_state;
  col_state_e                    w_state_nxt;
  logic [TXN_BITS-1:0]           r_txn_cnt;
  logic                          r_err_sticky;

  logic                          r_out_valid;
  logic [SLEN-1:0]               r_out_data;
  logic [NB-1:0]                 r_out_nbe;
  logic                          r_out_seg_last;
  logic                          r_out_req_last;
  logic                          r_out_err;

  seg_meta_t                     w_push_meta;
  seg_meta_t                     w_head;
  logic                          w_head_valid;
  logic [$clog2(META_DEPTH):0]   w_count_nxt;
  logic                          w_accept;
  logic                          w_first;
  logic                          w_last;
  logic [NB_W-1:0]               w_lo;
  logic [NB_W:0]                 w_hi;
  logic                          w_pop;

  assign w_push_meta = '{page_off: seg_page_off, txn_num: seg_txn_num,
                         ltn: seg_ltn, req_last: seg_req_last};

  vlsu_meta_fifo #(
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (seg_valid),
    .o_push_ready (seg_ready),
    .i_push_data  (w_push_meta),
    .o_pop_valid  (w_head_valid),
    .i_pop_ready  (w_pop),
    .o_pop_data   (w_head),
    .o_count_nxt  (w_count_nxt)
  );

  assign w_accept = rsp_valid && rsp_ready;
  assign w_first  = (r_txn_cnt == '0);
  assign w_last   = (r_txn_cnt == w_head.txn_num);
  assign w_lo     = w_first ? w_head.page_off : '0;
  assign w_hi     = w_last ? w_head.ltn : C_NB_FULL;
  assign w_pop    = w_accept && w_last;

  always_comb begin
    w_state_nxt = r_state;
    rsp_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        rsp_ready = !r_out_valid || out_ready;
        if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_txn_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_last) begin
          r_txn_cnt    <= '0;
          r_err_sticky <= 1'b0;
        end else begin
          r_txn_cnt <= r_txn_cnt + TXN_BITS'(1);
          if (rsp_err) r_err_sticky <= 1'b1;
        end
      end
    end
  end

  // Payload only loads on acceptance, so it stays put while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_nbe      <= '0;
      r_out_seg_last <= 1'b0;
      r_out_req_last <= 1'b0;
      r_out_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_out_data     <= rsp_data;
        r_out_nbe      <= nbe_mask(w_lo, w_hi);
        r_out_seg_last <= w_last;
        r_out_req_last <= w_last && w_head.req_last;
        r_out_err      <= r_err_sticky || rsp_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_nbe      = r_out_nbe;
  assign out_seg_last = r_out_seg_last;
  assign out_req_last = r_out_req_last;
  assign out_err      = r_out_err;

  a_ltn_nonzero: assert property (@(posedge clk) disable iff (rst)
    (seg_valid && seg_ready) |-> (seg_ltn != '0));

  a_single_txn_edges: assert property (@(posedge clk) disable iff (rst)
    (seg_valid && seg_ready && (seg_txn_num == '0)) |-> ({1'b0, seg_page_off} < seg_ltn));

  a_busy_has_head: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_BUSY) |-> w_head_valid);

endmodule

`default_nettype wire
